bldc_seq_ctrl: RTL

BLDC_SEQ_CTRL -- requirements
Module: bldc_seq_ctrl

---
 rtl/bldc_seq_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bldc_seq_ctrl.sv
// BLDC commutation supervisor: synchronises hall sensors, ramps PWM duty toward
// a target, measures hall period and latches invalid-hall / sequence / stall faults.
module bldc_seq_ctrl #(
    parameter int RAMP_DIV    = 256,
    parameter int STALL_LIMIT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  duty_target,
    input  logic        H1,
    input  logic        H2,
    input  logic        H3,
    input  logic        clear_fault,
    output logic        pwm_en,
    output logic [7:0]  pwm_in,
    output logic [1:0]  state,
    output logic [1:0]  fault_code,
    output logic [15:0] hall_period
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0]  FC_NONE    = 2'd0;
    localparam logic [1:0]  FC_INVALID = 2'd1;
    localparam logic [1:0]  FC_SEQ     = 2'd2;
    localparam logic [1:0]  FC_STALL   = 2'd3;
    localparam logic [15:0] PRESC_LAST = 16'(RAMP_DIV - 1);
    localparam logic [15:0] STALL_CNT  = 16'(STALL_LIMIT);
    localparam logic [2:0]  IDX_BAD    = 3'd7;

    // Position of a hall code on the commutation ring; 7 marks 000/111.
    function automatic logic [2:0] ring_idx(input logic [2:0] code);
        case (code)
            3'b101:  ring_idx = 3'd0;
            3'b100:  ring_idx = 3'd1;
            3'b110:  ring_idx = 3'd2;
            3'b010:  ring_idx = 3'd3;
            3'b011:  ring_idx = 3'd4;
            3'b001:  ring_idx = 3'd5;
            default: ring_idx = IDX_BAD;
        endcase
    endfunction

    logic [2:0]  h_meta_q, hall_s_q, hall_q_q;
    logic [1:0]  blank_q, blank_d;
    logic [15:0] period_cnt_q, period_cnt_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] hall_period_q, hall_period_d;
    logic [7:0]  pwm_in_q, pwm_in_d;
    logic        pwm_en_q, pwm_en_d;
    logic [1:0]  fault_code_q, fault_code_d;
    state_t      state_q, state_d;

    logic [2:0] idx_s, idx_q;
    logic       armed, hall_invalid, edge_known, step_fwd, step_rev;
    logic       legal_edge, seq_err;

    always_comb begin
        idx_s        = ring_idx(hall_s_q);
        idx_q        = ring_idx(hall_q_q);
        armed        = (blank_q == 2'd3);
        hall_invalid = armed && (idx_s == IDX_BAD);
        // Edges out of an invalid code are neither legal nor a sequence error.
        edge_known   = armed && (hall_s_q != hall_q_q) && (idx_s != IDX_BAD) && (idx_q != IDX_BAD);
        step_fwd     = (idx_q == 3'd5) ? (idx_s == 3'd0) : (idx_s == idx_q + 3'd1);
        step_rev     = (idx_s == 3'd5) ? (idx_q == 3'd0) : (idx_q == idx_s + 3'd1);
        legal_edge   = edge_known && (step_fwd || step_rev);
        seq_err      = edge_known && !(step_fwd || step_rev);
    end

    always_comb begin
        state_d       = state_q;
        fault_code_d  = fault_code_q;
        pwm_in_d      = pwm_in_q;
        presc_d       = presc_q;
        hall_period_d = hall_period_q;
        blank_d       = armed ? blank_q : blank_q + 2'd1;
        period_cnt_d  = (period_cnt_q == 16'hFFFF) ? period_cnt_q : period_cnt_q + 16'd1;

        // The captured period includes this clock's increment, so edges N clocks apart read N.
        if (legal_edge) begin
            hall_period_d = period_cnt_d;
            period_cnt_d  = 16'd0;
        end

        case (state_q)
            ST_IDLE: begin
                presc_d = 16'd0;
                if (enable && hall_invalid) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_INVALID;
                end else if (enable && armed) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP, ST_RUN: begin
                if (hall_invalid) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_INVALID;
                end else if (seq_err) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_SEQ;
                end else if (state_q == ST_RUN && period_cnt_q == STALL_CNT) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_STALL;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if (state_q == ST_RAMP) begin
                    if (pwm_in_q == duty_target) begin
                        state_d      = ST_RUN;
                        period_cnt_d = 16'd0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d  = 16'd0;
                        pwm_in_d = (pwm_in_q < duty_target) ? pwm_in_q + 8'd1 : pwm_in_q - 8'd1;
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end else if (pwm_in_q != duty_target) begin
                    state_d = ST_RAMP;
                    presc_d = 16'd0;
                end
            end
            default: begin
                if (clear_fault && !enable) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FC_NONE;
                end
            end
        endcase

        if (state_d == ST_IDLE || state_d == ST_FAULT) begin
            pwm_in_d = 8'd0;
        end
        pwm_en_d = (state_d == ST_RAMP) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_meta_q      <= 3'b000;
            hall_s_q      <= 3'b000;
            hall_q_q      <= 3'b000;
            blank_q       <= 2'd0;
            period_cnt_q  <= 16'd0;
            presc_q       <= 16'd0;
            hall_period_q <= 16'd0;
            pwm_in_q      <= 8'd0;
            pwm_en_q      <= 1'b0;
            fault_code_q  <= FC_NONE;
            state_q       <= ST_IDLE;
        end else begin
            h_meta_q      <= {H1, H2, H3};
            hall_s_q      <= h_meta_q;
            hall_q_q      <= hall_s_q;
            blank_q       <= blank_d;
            period_cnt_q  <= period_cnt_d;
            presc_q       <= presc_d;
            hall_period_q <= hall_period_d;
            pwm_in_q      <= pwm_in_d;
            pwm_en_q      <= pwm_en_d;
            fault_code_q  <= fault_code_d;
            state_q       <= state_d;
        end
    end

    assign pwm_en      = pwm_en_q;
    assign pwm_in      = pwm_in_q;
    assign state       = state_q;
    assign fault_code  = fault_code_q;
    assign hall_period = hall_period_q;

endmodule
